// File: rtl/pwm_mod_counter.sv
// pwm_mod_counter: modulo up/down counter with terminal-count pulse and N_CH
//   double-buffered PWM compare channels sharing one period.
// Latency: o_counter/o_tc one edge after the qualifying inputs; o_pwm lags o_counter by one cycle.
// Backpressure: none; i_en gates counting and all writes are accepted every cycle.
// Optional feature: define COUNTER_PRESCALE_EN to add a PRESCALE-cycle step prescaler.
module pwm_mod_counter #(
  parameter int WIDTH    = 10,
  parameter int MODULO   = 1000,
  parameter int N_CH     = 4
`ifdef COUNTER_PRESCALE_EN
  ,
  parameter int PRESCALE = 100
`endif
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_en,
  input  logic                   i_clear,
  input  logic                   i_load,
  input  logic [WIDTH-1:0]       i_load_val,
  input  logic                   i_dir,
  input  logic                   i_duty_we,
  input  logic [N_CH*WIDTH-1:0]  i_duty,
  output logic [WIDTH-1:0]       o_counter,
  output logic                   o_tc,
  output logic [N_CH-1:0]        o_pwm
);

  // Highest legal count and the modulus widened by one bit so that
  // MODULO == 2**WIDTH can still be compared against a load value.
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  // Counter state and registered outputs.
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic [N_CH-1:0]  pwm_q, pwm_d;

  // Duty buffers: software writes land in shadow, the comparators use active.
  // Packed so channel k occupies bits [k*WIDTH +: WIDTH], matching i_duty.
  logic [N_CH-1:0][WIDTH-1:0] shadow_q, shadow_d;
  logic [N_CH-1:0][WIDTH-1:0] active_q, active_d;

  // Internal qualifiers.
  logic             step;
  logic             wrap;
  logic [WIDTH-1:0] load_clamped;

`ifdef COUNTER_PRESCALE_EN
  // Prescaler: one count step per PRESCALE enabled cycles.
  localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PRE_ONE = PW'(1);

  logic [PW-1:0] pre_q, pre_d;
  logic          pre_tick;

  // Prescaler next state: held while disabled, restarted by clear/load so a
  // freshly loaded value always gets a full PRESCALE interval.
  always_comb begin
    pre_tick = (pre_q == PRE_MAX);
    pre_d    = pre_q;
    if (i_clear || i_load) begin
      pre_d = '0;
    end else if (i_en) begin
      pre_d = pre_tick ? '0 : (pre_q + PRE_ONE);
    end
  end

  // Prescaler register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign step = i_en && pre_tick;
`else
  // Without the prescaler every enabled cycle is a count step.
  assign step = i_en;
`endif

  // Out-of-range load values saturate at the top of the count range.
  assign load_clamped = ({1'b0, i_load_val} >= MOD_EXT) ? CNT_MAX : i_load_val;

  // Counter next state: clear > load > count; only a counted wrap raises tc.
  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_load) begin
      cnt_d = load_clamped;
    end else if (step) begin
      if (i_dir) begin
        if (cnt_q == '0) begin
          cnt_d = CNT_MAX;
          wrap  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end else begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          wrap  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    end
    tc_d = wrap;
  end

  // Duty buffers: active takes the shadow value held before the wrap edge, so
  // a write coinciding with a wrap only reaches the comparators next period.
  always_comb begin
    shadow_d = i_duty_we ? i_duty : shadow_q;
    active_d = wrap ? shadow_q : active_q;
  end

  // Comparators on pre-edge state; active >= MODULO always exceeds the count,
  // active == 0 never does, giving the constant-high / constant-low cases.
  always_comb begin
    pwm_d = '0;
    for (int k = 0; k < N_CH; k++) begin
      pwm_d[k] = (cnt_q < active_q[k]);
    end
  end

  // State registers; reset overrides everything and discards pending duty.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q    <= '0;
      tc_q     <= 1'b0;
      pwm_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      tc_q     <= tc_d;
      pwm_q    <= pwm_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign o_counter = cnt_q;
  assign o_tc      = tc_q;
  assign o_pwm     = pwm_q;

endmodule

// File: tb/tb_pwm_mod_counter.sv
// Testbench for pwm_mod_counter: directed vector table for counter control
// plus hand-written multi-cycle sequences for wrap, PWM duty and prescaler.
module tb_pwm_mod_counter;
  localparam int W = 10;
  localparam int M = 1000;
  localparam int N = 4;

  logic             i_clk = 1'b0;
  logic             i_reset, i_en, i_clear, i_load, i_dir, i_duty_we;
  logic [W-1:0]     i_load_val;
  logic [N*W-1:0]   i_duty;
  logic [W-1:0]     o_counter;
  logic             o_tc;
  logic [N-1:0]     o_pwm;

  always #5 i_clk = ~i_clk;

  pwm_mod_counter #(
    .WIDTH(W), .MODULO(M), .N_CH(N)
`ifdef COUNTER_PRESCALE_EN
    , .PRESCALE(4)
`endif
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_en(i_en), .i_clear(i_clear),
    .i_load(i_load), .i_load_val(i_load_val), .i_dir(i_dir),
    .i_duty_we(i_duty_we), .i_duty(i_duty),
    .o_counter(o_counter), .o_tc(o_tc), .o_pwm(o_pwm)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Advance one edge and settle; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_reset = 0; i_en = 0; i_clear = 0; i_load = 0; i_load_val = '0;
    i_dir = 0; i_duty_we = 0;
  endtask

  typedef struct {
    logic         clr;
    logic         ld;
    logic [W-1:0] lv;
    logic         en;
    logic         dir;
    logic [W-1:0] exp_cnt;
    logic         exp_tc;
  } vec_t;

  vec_t vt [17];
  int   highs [N];
  int   errs;
  logic [W-1:0] prev;

`ifndef COUNTER_PRESCALE_EN
  // Count PWM highs per channel over 'n' cycles; also check the one-cycle lag of ch0.
  task automatic run_period(input int n, input int duty0);
    for (int k = 0; k < N; k++) highs[k] = 0;
    errs = 0;
    for (int j = 0; j < n; j++) begin
      prev = o_counter;
      tick();
      for (int k = 0; k < N; k++) highs[k] += int'(o_pwm[k]);
      if (o_pwm[0] !== (int'(prev) < duty0)) errs++;
    end
  endtask
`endif

  initial begin
    idle();
    i_duty = '0;
    tick();

    // Reset overrides enable and load.
    i_reset = 1; i_en = 1; i_load = 1; i_load_val = 10'd300;
    tick();
    idle();
    chk("reset_cnt", 32'(o_counter), 0);
    chk("reset_tc",  32'(o_tc), 0);
    chk("reset_pwm", 32'(o_pwm), 0);

`ifndef COUNTER_PRESCALE_EN
    //          clr ld  lv    en dir  cnt  tc
    vt[0]  = '{0, 0, 10'd0,    1, 0, 10'd1,   0};
    vt[1]  = '{0, 0, 10'd0,    1, 0, 10'd2,   0};
    vt[2]  = '{0, 0, 10'd0,    0, 0, 10'd2,   0};
    vt[3]  = '{0, 1, 10'd1020, 0, 0, 10'd999, 0};
    vt[4]  = '{0, 0, 10'd0,    1, 0, 10'd0,   1};
    vt[5]  = '{0, 0, 10'd0,    1, 1, 10'd999, 1};
    vt[6]  = '{0, 0, 10'd0,    1, 1, 10'd998, 0};
    vt[7]  = '{0, 1, 10'd500,  1, 0, 10'd500, 0};
    vt[8]  = '{0, 0, 10'd0,    1, 1, 10'd499, 0};
    vt[9]  = '{0, 0, 10'd0,    1, 0, 10'd500, 0};
    vt[10] = '{1, 1, 10'd7,    1, 0, 10'd0,   0};
    vt[11] = '{0, 0, 10'd0,    1, 1, 10'd999, 1};
    vt[12] = '{0, 1, 10'd999,  1, 0, 10'd999, 0};
    vt[13] = '{1, 0, 10'd0,    1, 0, 10'd0,   0};
    vt[14] = '{0, 1, 10'd0,    1, 1, 10'd0,   0};
    vt[15] = '{0, 1, 10'd1000, 0, 0, 10'd999, 0};
    vt[16] = '{0, 1, 10'd998,  0, 0, 10'd998, 0};
    for (int v = 0; v < 17; v++) begin
      i_clear = vt[v].clr; i_load = vt[v].ld; i_load_val = vt[v].lv;
      i_en = vt[v].en; i_dir = vt[v].dir;
      tick();
      chk($sformatf("vec%0d_cnt", v), 32'(o_counter), 32'(vt[v].exp_cnt));
      chk($sformatf("vec%0d_tc", v),  32'(o_tc), 32'(vt[v].exp_tc));
    end
    idle();

    // Full up-count period from reset: 0..999 then wrap with a single tc pulse.
    i_reset = 1; tick(); idle();
    i_en = 1;
    errs = 0;
    for (int i = 1; i <= M; i++) begin
      tick();
      if (int'(o_counter) != (i % M)) errs++;
      if (o_tc !== ((i % M) == 0)) errs++;
    end
    chk("period_errs", 32'(errs), 0);
    chk("period_wrap_cnt", 32'(o_counter), 0);
    chk("period_wrap_tc", 32'(o_tc), 1);
    tick();
    chk("period_tc_drop", 32'(o_tc), 0);
    idle();

    // Duty channels 250 / 0 / 1000 / 999 take effect at the next wrap.
    i_reset = 1; tick(); idle();
    i_duty = {10'd999, 10'd1000, 10'd0, 10'd250};
    i_duty_we = 1; tick(); i_duty_we = 0;
    i_load = 1; i_load_val = 10'd999; tick(); i_load = 0;
    chk("duty_pre_pwm", 32'(o_pwm), 0);
    i_en = 1; tick();
    chk("duty_wrap_tc", 32'(o_tc), 1);
    chk("duty_wrap_pwm", 32'(o_pwm), 0);
    run_period(M, 250);
    chk("duty_ch0_highs", 32'(highs[0]), 250);
    chk("duty_ch1_highs", 32'(highs[1]), 0);
    chk("duty_ch2_highs", 32'(highs[2]), 1000);
    chk("duty_ch3_highs", 32'(highs[3]), 999);
    chk("duty_lag_errs", 32'(errs), 0);

    // Duty write coinciding with a wrap reaches the comparator one period later.
    i_en = 0; i_load = 1; i_load_val = 10'd999; tick(); i_load = 0;
    i_duty = {10'd999, 10'd1000, 10'd0, 10'd600};
    i_duty_we = 1; i_en = 1; tick(); i_duty_we = 0;
    chk("wrapwr_tc", 32'(o_tc), 1);
    run_period(M, 250);
    chk("wrapwr_old_highs", 32'(highs[0]), 250);
    run_period(M, 600);
    chk("wrapwr_new_highs", 32'(highs[0]), 600);
    chk("wrapwr_lag_errs", 32'(errs), 0);

    // Reset at count 400 clears outputs and loses the pending shadow.
    i_en = 1; i_load = 1; i_load_val = 10'd400; tick(); i_load = 0;
    chk("midrst_cnt_pre", 32'(o_counter), 400);
    i_duty = {N{10'd700}}; i_duty_we = 1; tick(); i_duty_we = 0;
    i_reset = 1; tick(); i_reset = 0;
    chk("midrst_cnt", 32'(o_counter), 0);
    chk("midrst_tc", 32'(o_tc), 0);
    chk("midrst_pwm", 32'(o_pwm), 0);
    i_en = 1;
    run_period(M + 1, 0);
    chk("midrst_highs", 32'(highs[0] + highs[1] + highs[2] + highs[3]), 0);
    idle();
`else
    // Prescaler of 4: one step per four enabled cycles.
    i_en = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("pre_hold%0d", i), 32'(o_counter), 0);
    end
    tick();
    chk("pre_step1", 32'(o_counter), 1);
    tick(); tick();
    i_en = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("pre_dis%0d", i), 32'(o_counter), 1);
    end
    i_en = 1;
    tick();
    chk("pre_resume", 32'(o_counter), 1);
    tick();
    chk("pre_step2", 32'(o_counter), 2);

    // Load restarts the prescaler.
    tick(); tick();
    i_load = 1; i_load_val = 10'd5; tick(); i_load = 0;
    chk("pre_load", 32'(o_counter), 5);
    tick(); tick(); tick();
    chk("pre_load_hold", 32'(o_counter), 5);
    tick();
    chk("pre_load_step", 32'(o_counter), 6);

    // Down-count wrap after a prescaled interval.
    i_load = 1; i_load_val = 10'd0; tick(); i_load = 0;
    i_dir = 1;
    tick(); tick(); tick();
    chk("pre_down_hold", 32'(o_counter), 0);
    chk("pre_down_tc0", 32'(o_tc), 0);
    tick();
    chk("pre_down_wrap", 32'(o_counter), 999);
    chk("pre_down_tc", 32'(o_tc), 1);
    tick();
    chk("pre_down_tc_drop", 32'(o_tc), 0);
    idle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
